// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; DEPTH must be a power of two >= 2.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t      mem_r [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;

  // Storage, pointers and occupancy; a flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, redirect handling and a fetch queue toward decode.
// Optional misaligned-redirect flag enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        im_addr,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               misalign
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc_r;
  logic [CW-1:0] count_s;
  logic          space_s;
  logic          pop_s;
  logic          push_s;
  fetch_entry_t  din_s;
  fetch_entry_t  head_s;

  assign im_addr  = pc_r;
  assign id_valid = (count_s != {CW{1'b0}});
  assign space_s  = (count_s < CW'(QDEPTH));
  assign pop_s    = id_valid & id_ready;
  // A full queue still accepts a push when decode drains the head this cycle.
  assign push_s   = ~redirect & (space_s | pop_s);

  assign din_s.pc    = pc_r;
  assign din_s.instr = im_data;

  // Program counter: redirect has priority, otherwise advance on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect) begin
      pc_r <= align_pc(redirect_pc);
    end else if (push_s) begin
      pc_r <= pc_r + PC_INC;
    end else begin
      pc_r <= pc_r;
    end
  end

  if_fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .din   (din_s),
    .count (count_s),
    .head  (head_s)
  );

  assign id_instr = head_s.instr;
  assign id_pc    = head_s.pc;
  assign id_pc4   = id_valid ? (head_s.pc + PC_INC) : 32'h0000_0000;

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_r;

  // Sticky until reset once any redirect target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a queue-based reference model and per-cycle comparison.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    return 32'h1000_0000 + {24'h0, a[9:2]};
  endfunction

  assign im_data = mem_word(im_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } mentry_t;

  mentry_t     mq[$];
  logic [31:0] mpc;
  logic        mmis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc  = RESET_PC;
    mmis = 1'b0;
  endtask

  task automatic model_step();
    bit      do_pop;
    bit      do_push;
    mentry_t e;
    if (redirect) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
`ifdef IF_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
`endif
    end else begin
      do_pop  = (mq.size() != 0) && id_ready;
      do_push = (mq.size() < QDEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc    = mpc;
        e.instr = mem_word(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("id_valid", {31'h0, id_valid}, {31'h0, (mq.size() != 0)});
    chk("im_addr", im_addr, mpc);
    chk("misalign", {31'h0, misalign}, {31'h0, mmis});
    if (mq.size() != 0) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_instr", id_instr, mq[0].instr);
      chk("id_pc4", id_pc4, mq[0].pc + 32'd4);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n       = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #3;
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_addr", im_addr, RESET_PC);
    chk("rst_mis", {31'h0, misalign}, 32'h0);

    // Streaming from reset with decode always ready.
    id_ready = 1'b1;
    #9 rst_n = 1'b1;
    step();
    chk("t1_valid", {31'h0, id_valid}, 32'h1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_instr0", id_instr, 32'h1000_0000);
    step();
    chk("t1_pc1", id_pc, 32'h4);
    chk("t1_instr1", id_instr, 32'h1000_0001);
    step();
    chk("t1_pc2", id_pc, 32'h8);
    chk("t1_instr2", id_instr, 32'h1000_0002);

    // Asynchronous reset pulse between edges.
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'h0, id_valid}, 32'h0);
    chk("t5_addr", im_addr, RESET_PC);
    id_ready = 1'b0;
    #3 rst_n = 1'b1;

    // Stall until full, then drain with no gap.
    repeat (5) step();
    chk("t2_valid", {31'h0, id_valid}, 32'h1);
    chk("t2_pc_hold", id_pc, 32'h0);
    chk("t2_addr", im_addr, 32'h8);
    id_ready = 1'b1;
    step();
    chk("t2_pc4", id_pc, 32'h4);
    step();
    chk("t2_pc8", id_pc, 32'h8);
    chk("t2_v8", {31'h0, id_valid}, 32'h1);

    // Redirect while full.
    id_ready    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    chk("t3_bubble", {31'h0, id_valid}, 32'h0);
    step();
    chk("t3_valid", {31'h0, id_valid}, 32'h1);
    chk("t3_pc", id_pc, 32'h40);
    chk("t3_pc4", id_pc4, 32'h44);

    // Redirect to the top of the address space and wrap.
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("t4_bubble", {31'h0, id_valid}, 32'h0);
    step();
    chk("t4_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("t4_pc4_wrap", id_pc4, 32'h0);
    chk("t4_instr", id_instr, 32'h1000_00FF);
    step();
    chk("t4_pc_0", id_pc, 32'h0);
    step();
    chk("t4_pc_4", id_pc, 32'h4);

    // Misaligned redirect, then an aligned one to show stickiness.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0042;
    step();
    redirect = 1'b0;
    step();
    chk("t6_pc", id_pc, 32'h40);
`ifdef IF_ALIGN_CHECK_EN
    chk("t6_mis", {31'h0, misalign}, 32'h1);
`else
    chk("t6_mis", {31'h0, misalign}, 32'h0);
`endif
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    redirect = 1'b0;
    step();
    chk("t6_pc80", id_pc, 32'h80);
`ifdef IF_ALIGN_CHECK_EN
    chk("t6_sticky", {31'h0, misalign}, 32'h1);
`else
    chk("t6_sticky", {31'h0, misalign}, 32'h0);
`endif
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage placed directly upstream of the instruction memory.
- Holds the PC and drives the word address into the instruction memory; that memory returns the word combinationally in the same cycle.
- Buffers fetched {pc, instr} pairs in a small queue and presents them to decode with a valid/ready handshake.
- Handles redirects (branch/jump/exception) by flushing the queue and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, fetch queue entries; must be a power of two and at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- im_addr  out  32  byte address to instruction memory; the memory uses bits [9:2]
- im_data  in  32  instruction word returned combinationally for im_addr
- redirect  in  1  one-cycle pulse that loads redirect_pc and flushes the queue
- redirect_pc  in  32  redirect target byte address
- id_valid  out  1  queue head holds a valid instruction
- id_ready  in  1  decode accepts the head this cycle
- id_instr  out  32  head instruction
- id_pc  out  32  head PC
- id_pc4  out  32  head PC + 4
- misalign  out  1  sticky flag for a misaligned redirect (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, queue count=0, read and write pointers=0, misalign=0.
  - id_valid=0; id_instr, id_pc and id_pc4 read 0.
  - Asserting reset mid-operation discards all queued entries immediately.
- Address path: im_addr = pc, purely combinational from the register. No other logic sits on im_addr.
- pop = id_valid & id_ready.
- push = ~redirect & (count<QDEPTH | pop).
  - A full queue accepts a push in the same cycle it pops, so throughput is 1 instruction/cycle.
  - This creates a combinational id_ready -> push path; that path is accepted.
- On push: enqueue {pc, im_data}; pc <= pc+4.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- count update: count <= count + push - pop.
- Head outputs:
  - id_valid = (count != 0).
  - id_instr and id_pc come from the head entry; id_pc4 = id_pc + 4.
  - Outputs stay stable while id_valid=1 and id_ready=0.
- Redirect has priority over push:
  - At the clock edge: pc <= redirect_pc (aligned as below), count <= 0, pointers <= 0.
  - A pop in the redirect cycle still counts as a completed transfer; decode is responsible for squashing it.
- Latency:
  - Reset release to first id_valid=1: 1 clock edge.
  - Redirect edge N: the target instruction is pushed at edge N+1 and id_valid=1 after N+1, giving one bubble cycle.
- Stall: with id_ready=0 and the queue full, pc holds and no push occurs.
- Empty: id_valid=0 and the id_* data outputs are don't-care; the bench must not check them.
- Redirect while empty or full behaves identically: the queue flushes and the PC reloads.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets misalign=1 (sticky until reset).
  - pc loads {redirect_pc[31:2], 2'b00}.
  - Fetch continues normally.
- Undefined:
  - redirect_pc[1:0] is ignored, so pc always loads {redirect_pc[31:2], 2'b00}.
  - misalign is tied to 0.

Decomposition:
- Shared package (if_pkg):
  - constant INSTR_W = 32;
  - constant PC_INC = 4;
  - packed typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module: if_fetch_queue, a synchronous FIFO of fetch_entry_t with push, pop, flush, count and head outputs.
- The PC/redirect logic stays in if_fetch.

Test Plan:
1. Reset, then release, with im_data = 32'h1000_0000 + im_addr[9:2] and id_ready=1 → id_pc sequence 0, 4, 8, …; id_instr 32'h1000_0000, 32'h1000_0001, …; id_valid=1 from the first edge on.
2. Hold id_ready=0 for 5 cycles → queue fills to QDEPTH; pc holds at 8; id_pc stays 0. Then set id_ready=1 → in-order delivery of 0, 4, then 8 with no gap.
3. redirect=1, redirect_pc=32'h0000_0040 while the queue is full → after the next edge id_valid=0 (one bubble); next edge id_pc=32'h40, id_pc4=32'h44.
4. Redirect to 32'hFFFF_FFFC → id_pc shows FFFF_FFFC, then 0, then 4 (wrap-around).
5. Pulse rst_n low asynchronously between edges during streaming → id_valid drops to 0 immediately; after release, id_pc=RESET_PC.
6. With IF_ALIGN_CHECK_EN defined, redirect to 32'h0000_0042 → misalign=1 and stays set; id_pc=32'h40. Without the macro → misalign=0 and id_pc=32'h40.
